// File: rtl/regfile_dump_streamer_pkg.sv
// Shared definitions for the regfile dump streamer: FSM state encoding and
// the default register-file geometry.
package regfile_dump_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } dump_state_e;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int CYCLE_W_DEF  = 10;

endpackage

// File: rtl/regfile_dump_streamer.sv
// Runs the processor for a programmed number of cycles, then freezes it and
// streams every register out of read port A as {index, value} beats.
module regfile_dump_streamer
  import regfile_dump_streamer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CYCLE_W  = CYCLE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] num_cycles,
  output logic               cpu_run,
  output logic               test_mode,
  output logic [REG_AW-1:0]  dump_reg,
  input  logic [DATA_W-1:0]  reg_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  out_index,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  dump_state_e        state_q, state_d;
  logic [CYCLE_W-1:0] ncyc_q;
  logic [CYCLE_W-1:0] cnt_q;
  logic [REG_AW-1:0]  idx_q;
  logic [REG_AW-1:0]  index_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               start_acc;
  logic               at_last;

  function automatic logic is_last_idx(input logic [REG_AW-1:0] idx);
    return idx == REG_AW'(NUM_REGS - 1);
  endfunction

  assign at_last = is_last_idx(idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (num_cycles == '0) ? ST_SETTLE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Leave on the edge that completes the last run cycle.
        if (cnt_q == ncyc_q - CYCLE_W'(1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_SEND;
      ST_SEND: begin
        if (out_ready) state_d = at_last ? ST_DONE : ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: counters advance and the settled read is captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ncyc_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      index_p1 <= '0;
      data_p1  <= '0;
    end else begin
      if (start_acc) begin
        ncyc_q <= num_cycles;
        cnt_q  <= '0;
        idx_q  <= '0;
      end
      if (state_q == ST_RUN) cnt_q <= cnt_q + CYCLE_W'(1);
      if (state_q == ST_SETTLE) begin
        data_p1  <= reg_data;
        index_p1 <= idx_q;
      end
      if (state_q == ST_SEND && out_ready && !at_last) idx_q <= idx_q + REG_AW'(1);
    end
  end

  // Stage p1: outputs decode directly from registered state.
  assign cpu_run   = (state_q == ST_RUN);
  assign test_mode = (state_q == ST_SETTLE) || (state_q == ST_SEND);
  assign dump_reg  = test_mode ? idx_q : '0;
  assign out_valid = (state_q == ST_SEND);
  assign out_last  = out_valid && at_last;
  assign out_index = index_p1;
  assign out_data  = data_p1;
  assign busy      = (state_q == ST_RUN) || test_mode;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Scoreboard bench for regfile_dump_streamer: a regfile model feeds read
// port A and a monitor compares every presented beat with the expected queue.
module tb_regfile_dump_streamer;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int CYCLE_W  = 10;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [CYCLE_W-1:0] num_cycles = '0;
  logic               out_ready = 1'b1;
  logic               cpu_run, test_mode, out_valid, out_last, busy, done;
  logic [REG_AW-1:0]  dump_reg, out_index;
  logic [DATA_W-1:0]  reg_data, out_data;

  logic [DATA_W-1:0]  regs [NUM_REGS];

  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cpu_run_cnt = 0;

  always #5 clock = ~clock;

  assign reg_data = regs[dump_reg];

  regfile_dump_streamer #(
    .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .DATA_W(DATA_W), .CYCLE_W(CYCLE_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_run(cpu_run), .test_mode(test_mode), .dump_reg(dump_reg),
    .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Pattern 0: r[i] = i*3. Pattern 1: r0 = 0, r[i] = 0xA5000000 + i*257.
  function automatic logic [DATA_W-1:0] exp_val(input int pat, input int i);
    if (pat == 0) return DATA_W'(i * 3);
    if (i == 0) return '0;
    return 32'hA500_0000 + DATA_W'(i * 257);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic load_and_expect(input int pat);
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i] = exp_val(pat, i);
      exp_q.push_back('{idx: REG_AW'(i), data: exp_val(pat, i), last: (i == NUM_REGS - 1)});
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge clock); #1;
    num_cycles = CYCLE_W'(n);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input int n, input int pat, input int stall_idx,
                          input bit poke, input int exp_edges);
    int edges = 0;
    int first_valid = -1;
    int stall_left = 0;
    int c0;
    bit stalled = 1'b0;
    load_and_expect(pat);
    pulse_start(n);
    check("start_accept", {62'd0, busy, done}, 64'b10);
    c0 = cpu_run_cnt;
    while (!done && edges < 3000) begin
      @(posedge clock); edges++; #1;
      if (out_valid && first_valid < 0) first_valid = edges;
      if (poke) begin
        if (edges == 2 || edges == n + 3) begin
          start = 1'b1;
          num_cycles = CYCLE_W'(9);
        end else begin
          start = 1'b0;
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (!stalled && stall_idx >= 0 && out_valid && out_index == REG_AW'(stall_idx)) begin
        out_ready  = 1'b0;
        stall_left = 10;
        stalled    = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    num_cycles = CYCLE_W'(n);
    check("done_reached", 64'(done), 64'd1);
    check("done_latency", 64'(edges), 64'(exp_edges));
    check("first_valid", 64'(first_valid), 64'(n + 1));
    check("cpu_run_cycles", 64'(cpu_run_cnt - c0), 64'(n));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("quiet_in_done", {60'd0, out_valid, test_mode, busy, cpu_run}, 64'd0);
    if (stall_idx >= 0) check("stall_applied", 64'(stalled), 64'd1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          check("invariant", {62'd0, cpu_run & test_mode, out_valid & ~test_mode}, 64'd0);
          if (cpu_run) cpu_run_cnt++;
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              check("unexpected_beat", 64'd1, 64'd0);
            end else begin
              check("beat_index", 64'(out_index), 64'(exp_q[0].idx));
              check("beat_data", 64'(out_data), 64'(exp_q[0].data));
              check("beat_last", 64'(out_last), 64'(exp_q[0].last));
              if (out_ready) void'(exp_q.pop_front());
            end
          end
        end
      end
    join_none

    // Power-on reset.
    #1 reset = 1'b0;
    #1 check("por_outputs", {16'd0, cpu_run, test_mode, dump_reg, out_valid, out_index,
                             out_data, out_last, busy, done}, 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    check("idle_after_reset", {62'd0, busy, done}, 64'd0);

    // Basic dump: 5 run cycles, r[i] = i*3.
    run_dump(5, 0, -1, 1'b0, 5 + 64);

    // Async reset while beat 7 is presented, then a clean dump.
    begin
      bit found = 1'b0;
      load_and_expect(1);
      pulse_start(2);
      for (int i = 0; i < 300 && !found; i++) begin
        @(negedge clock); #1;
        if (out_valid && out_index == REG_AW'(7)) found = 1'b1;
      end
      check("reached_index7", 64'(found), 64'd1);
      reset = 1'b0;
      #1 check("midsend_reset", {16'd0, cpu_run, test_mode, dump_reg, out_valid, out_index,
                                 out_data, out_last, busy, done}, 64'd0);
      exp_q.delete();
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;
    end
    run_dump(4, 1, -1, 1'b0, 4 + 64);

    // Zero-length run goes straight to the dump.
    run_dump(0, 0, -1, 1'b0, 64);

    // Backpressure at index 12 for 10 cycles.
    run_dump(1, 1, 12, 1'b0, 1 + 64 + 10);

    // Start pulses during RUN and SEND are ignored.
    run_dump(6, 0, -1, 1'b1, 6 + 64);

    // Restart straight from DONE.
    run_dump(3, 1, -1, 1'b0, 3 + 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
